// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner: key codes, keymap,
// scan FSM states and the row-priority helper.
package keypad_pkg;

    typedef logic [3:0] key_code_t;
    typedef logic [1:0] col_idx_t;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } scan_state_t;

    // Indexed [column][row]; row 0 is the top row of the physical pad.
    localparam key_code_t KEYMAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'hE},
        '{4'h2, 4'h5, 4'h8, 4'h0},
        '{4'h3, 4'h6, 4'h9, 4'hF},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    function automatic logic [1:0] highest_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        if (rows[3])      idx = 2'd3;
        else if (rows[2]) idx = 2'd2;
        else if (rows[1]) idx = 2'd1;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key-event handshake between the keypad scanner (master) and the key consumer (slave).
interface keypad_scan_ctrl_if;
    import keypad_pkg::*;

    logic      key_valid;
    key_code_t key_code;
    logic      key_ready;
    logic      key_held;
    logic      overrun;

    modport master (
        output key_valid,
        output key_code,
        output key_held,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_held,
        input  overrun,
        output key_ready
    );

endinterface

// File: rtl/keypad_scan_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module keypad_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 4'b0000;
            q    <= 4'b0000;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: column scan with settle time, per-key debounce on a
// frozen column, and a single valid/ready key event per press.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         row_in,
    output logic [3:0]         col,
    keypad_scan_ctrl_if.master key_if
);

    localparam logic [1:0] ST_SCAN    = 2'(SCAN);
    localparam logic [1:0] ST_CONFIRM = 2'(CONFIRM);
    localparam logic [1:0] ST_HELD    = 2'(HELD);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       rs;
    logic [1:0]       state;
    col_idx_t         col_idx;
    logic [1:0]       cap_row;
    logic [CNT_W-1:0] cnt;

    logic      key_valid;
    key_code_t key_code;
    logic      key_held;
    logic      overrun;

    logic row_hit;
    logic confirm;
    logic transfer;
    logic load;

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (rs)
    );

    assign row_hit  = rs[cap_row];
    assign confirm  = (state == ST_CONFIRM) && row_hit && (cnt == DEB_LAST);
    assign transfer = key_valid && key_if.key_ready;
    assign load     = confirm && (!key_valid || transfer);

    assign col = ~(4'b0001 << col_idx);

    // One counter serves settle, press debounce and release debounce, since only
    // one of them is live in any state; it is cleared on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SCAN;
            col_idx  <= 2'd0;
            cap_row  <= 2'd0;
            cnt      <= '0;
            key_held <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (rs != 4'b0000) begin
                            cap_row <= highest_row(rs);
                            state   <= ST_CONFIRM;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (!row_hit) begin
                        col_idx <= col_idx + 2'd1;
                        state   <= ST_SCAN;
                        cnt     <= '0;
                    end else if (cnt == DEB_LAST) begin
                        key_held <= 1'b1;
                        state    <= ST_HELD;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (row_hit) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        col_idx  <= col_idx + 2'd1;
                        state    <= ST_SCAN;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A confirmed key that finds the previous event still unaccepted is dropped
    // and flagged, so the consumer always sees the oldest unread key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            overrun   <= 1'b0;
        end else begin
            overrun <= confirm && key_valid && !key_if.key_ready;
            if (load) begin
                key_valid <= 1'b1;
                key_code  <= KEYMAP[col_idx][cap_row];
            end else if (transfer) begin
                key_valid <= 1'b0;
            end
        end
    end

    assign key_if.key_valid = key_valid;
    assign key_if.key_code  = key_code;
    assign key_if.key_held  = key_held;
    assign key_if.overrun   = overrun;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: exact-cycle scan/press/glitch/overrun/reset
// sequences plus a keymap table driven through a simple keypad matrix model.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int SETTLE = 4;
    localparam int DEB    = 8;

    typedef struct {
        int        c;
        int        r;
        key_code_t code;
    } key_vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col;
    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;

    key_vec_t vecs [16];

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .row_in (row_in),
        .col    (col),
        .key_if (kif)
    );

    always #5 clk = ~clk;

    // A closed key connects its row to its column; a row reads 1 only while its
    // key's column is being driven low.
    function automatic logic [3:0] keypad_rows(input logic [15:0] keys, input logic [3:0] drive);
        logic [3:0] rows;
        rows = 4'b0000;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !drive[c]) rows[r] = 1'b1;
        return rows;
    endfunction

    assign row_in = keypad_rows(pressed, col);

    function automatic logic [15:0] keyMask(input int c, input int r);
        return 16'h0001 << (c*4 + r);
    endfunction

    function automatic logic [3:0] colOf(input int idx);
        return 4'b1111 ^ (4'b0001 << (idx % 4));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input logic ready);
        pressed       = keys;
        kif.key_ready = ready;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus('0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runIdle();
        resetDut();
        for (int k = 0; k < 20; k++) begin
            checkOutput("idle col", col, colOf(k / SETTLE));
            checkOutput("idle valid", kif.key_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    // Key 6 at c2/r1, consumer always ready: sampled at edge 12, confirmed at edge 20,
    // released after cycle 60 so the release debounce completes at edge 70.
    task automatic runSinglePress();
        int exp_idx;
        resetDut();
        applyStimulus(keyMask(2, 1), 1'b1);
        for (int k = 0; k <= 76; k++) begin
            exp_idx = (k < 4) ? 0 : (k < 8) ? 1 : (k < 70) ? 2 : (k < 74) ? 3 : 0;
            checkOutput("press col", col, colOf(exp_idx));
            checkOutput("press valid", kif.key_valid, (k == 20));
            checkOutput("press held", kif.key_held, (k >= 20 && k < 70));
            checkOutput("press overrun", kif.overrun, 1'b0);
            if (k == 20) checkOutput("press code", kif.key_code, 4'h6);
            if (k == 60) applyStimulus('0, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic runGlitch();
        int exp_idx;
        resetDut();
        applyStimulus(keyMask(0, 2), 1'b1);
        for (int k = 0; k < 16; k++) begin
            exp_idx = (k < 8) ? 0 : (k < 12) ? 1 : 2;
            checkOutput("glitch col", col, colOf(exp_idx));
            checkOutput("glitch valid", kif.key_valid, 1'b0);
            checkOutput("glitch held", kif.key_held, 1'b0);
            if (k == 5) applyStimulus('0, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic runOverrun();
        int k;
        int bad;
        int pulses;
        resetDut();
        applyStimulus(keyMask(1, 1), 1'b0);
        k = 0;
        while (!kif.key_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("ovr first latency", k, 16);
        checkOutput("ovr first code", kif.key_code, 4'h5);

        bad = 0;
        pulses = 0;
        applyStimulus('0, 1'b0);
        k = 0;
        while (kif.key_held && k < 40) begin
            @(negedge clk);
            k++;
            if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h5) bad++;
            if (kif.overrun) pulses++;
        end
        checkOutput("ovr release seen", kif.key_held, 1'b0);

        applyStimulus(keyMask(2, 2), 1'b0);
        k = 0;
        while (!kif.key_held && k < 60) begin
            @(negedge clk);
            k++;
            if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h5) bad++;
            if (kif.overrun) pulses++;
        end
        checkOutput("ovr second held", kif.key_held, 1'b1);
        checkOutput("ovr pulse at confirm", kif.overrun, 1'b1);
        checkOutput("ovr col frozen", col, colOf(2));
        @(negedge clk);
        checkOutput("ovr pulse width", kif.overrun, 1'b0);
        checkOutput("ovr pulse count", pulses, 1);
        checkOutput("ovr code kept", bad, 0);
        checkOutput("ovr valid kept", kif.key_valid, 1'b1);

        applyStimulus(keyMask(2, 2), 1'b1);
        @(negedge clk);
        applyStimulus(keyMask(2, 2), 1'b0);
        checkOutput("ovr drained", kif.key_valid, 1'b0);
        @(negedge clk);
        checkOutput("ovr stays empty", kif.key_valid, 1'b0);
        applyStimulus('0, 1'b0);
    endtask

    task automatic runTwoRowsAndReset();
        int k;
        resetDut();
        applyStimulus(keyMask(3, 0) | keyMask(3, 3), 1'b0);
        k = 0;
        while (!kif.key_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("multi latency", k, 24);
        checkOutput("multi code", kif.key_code, 4'hD);
        checkOutput("multi held", kif.key_held, 1'b1);
        checkOutput("multi col", col, colOf(3));
        repeat (2) @(negedge clk);

        rst_n = 1'b0;
        #1;
        checkOutput("rst col", col, 4'b1110);
        checkOutput("rst valid", kif.key_valid, 1'b0);
        checkOutput("rst held", kif.key_held, 1'b0);
        checkOutput("rst overrun", kif.overrun, 1'b0);
        checkOutput("rst code", kif.key_code, 4'h0);
        applyStimulus('0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checkOutput("rst restart col", col, colOf(j / SETTLE));
            checkOutput("rst restart valid", kif.key_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic runKeymapTable();
        int k;
        for (int i = 0; i < 16; i++) begin
            resetDut();
            applyStimulus(keyMask(vecs[i].c, vecs[i].r), 1'b1);
            k = 0;
            while (!kif.key_valid && k < 60) begin
                @(negedge clk);
                k++;
            end
            checkOutput("tbl valid", kif.key_valid, 1'b1);
            checkOutput("tbl code", kif.key_code, vecs[i].code);
            checkOutput("tbl col", col, colOf(vecs[i].c));
            @(negedge clk);
            checkOutput("tbl consumed", kif.key_valid, 1'b0);
            checkOutput("tbl held", kif.key_held, 1'b1);
            applyStimulus('0, 1'b1);
            k = 0;
            while (kif.key_held && k < 40) begin
                @(negedge clk);
                k++;
            end
            checkOutput("tbl released", kif.key_held, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        kif.key_ready = 1'b0;
        vecs[0]  = '{0, 0, 4'h1};  vecs[1]  = '{0, 1, 4'h4};
        vecs[2]  = '{0, 2, 4'h7};  vecs[3]  = '{0, 3, 4'hE};
        vecs[4]  = '{1, 0, 4'h2};  vecs[5]  = '{1, 1, 4'h5};
        vecs[6]  = '{1, 2, 4'h8};  vecs[7]  = '{1, 3, 4'h0};
        vecs[8]  = '{2, 0, 4'h3};  vecs[9]  = '{2, 1, 4'h6};
        vecs[10] = '{2, 2, 4'h9};  vecs[11] = '{2, 3, 4'hF};
        vecs[12] = '{3, 0, 4'hA};  vecs[13] = '{3, 1, 4'hB};
        vecs[14] = '{3, 2, 4'hC};  vecs[15] = '{3, 3, 4'hD};

        @(negedge clk);
        checkOutput("por col", col, 4'b1110);
        checkOutput("por valid", kif.key_valid, 1'b0);

        $display("[TB] idle scan");
        runIdle();
        $display("[TB] single press with ready");
        runSinglePress();
        $display("[TB] glitch rejection");
        runGlitch();
        $display("[TB] overrun with consumer stalled");
        runOverrun();
        $display("[TB] two rows and reset during held");
        runTwoRowsAndReset();
        $display("[TB] keymap table");
        runKeymapTable();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
